register_file_bank: RTL and testbench



---
 rtl/register_file_bank.sv | 144 ++++++++++++++
 tb/tb_register_file_bank.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_bank.sv
// register_file_bank: general-purpose register file with one write port and
// two registered read ports. After every reset a clear sequencer walks the
// whole array writing zero before the bank reports ready.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to a
// read port addressing the register being written; without it reads return
// the pre-write value.
module register_file_bank #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] read_reg_0,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    output logic [DATA_WIDTH-1:0] read_data_0,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic                  ready,
    output logic                  write_dropped
);

    // Array index width; the upper address bits only matter for range checks.
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH + 1)'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH:0] REG_COUNT = (ADDR_WIDTH + 1)'(NUM_REGS);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH:0]   clear_idx_reg, clear_idx_next;
    logic                  write_dropped_reg, write_dropped_next;

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  write_in_range;
    logic [ADDR_WIDTH-1:0] read_idx [2];
    logic [DATA_WIDTH-1:0] read_data_reg [2];

    assign write_in_range = ({1'b0, write_address} < REG_COUNT);
    assign read_idx[0]    = read_reg_0;
    assign read_idx[1]    = read_reg_1;

    // State register: sequencer state, clear pointer and drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_CLEAR;
            clear_idx_reg     <= '0;
            write_dropped_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            clear_idx_reg     <= clear_idx_next;
            write_dropped_reg <= write_dropped_next;
        end
    end

    // Next state: CLEAR walks every index once, READY holds until reset.
    always_comb begin
        state_next     = state_reg;
        clear_idx_next = clear_idx_reg;
        case (state_reg)
            ST_CLEAR: begin
                clear_idx_next = clear_idx_reg + 1'b1;
                if (clear_idx_reg == LAST_IDX) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                state_next = ST_READY;
            end
            default: begin
                state_next     = ST_CLEAR;
                clear_idx_next = '0;
            end
        endcase
    end

    // Outputs of the FSM: select the single array write and flag dropped writes.
    always_comb begin
        mem_we             = 1'b0;
        mem_waddr          = write_address[IDX_W-1:0];
        mem_wdata          = write_data;
        write_dropped_next = 1'b0;
        if (state_reg == ST_READY) begin
            mem_we             = write_enable && write_in_range;
            write_dropped_next = write_enable && !write_in_range;
        end else begin
            // The clear write owns the port; any core write is discarded.
            mem_we             = 1'b1;
            mem_waddr          = clear_idx_reg[IDX_W-1:0];
            mem_wdata          = '0;
            write_dropped_next = write_enable;
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            logic                  rd_in_range;
            logic [DATA_WIDTH-1:0] rd_next;

            assign rd_in_range = ({1'b0, read_idx[gi]} < REG_COUNT);

            // Read mux: zero when not ready or out of range, optional forwarding.
            always_comb begin
                rd_next = '0;
                if (state_reg == ST_READY && rd_in_range) begin
                    rd_next = mem[read_idx[gi][IDX_W-1:0]];
`ifdef REGFILE_WRITE_BYPASS_EN
                    if (write_enable && write_in_range && (read_idx[gi] == write_address)) begin
                        rd_next = write_data;
                    end
`endif
                end
            end

            // Registered read data, cleared by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    read_data_reg[gi] <= '0;
                end else begin
                    read_data_reg[gi] <= rd_next;
                end
            end
        end
    endgenerate

    assign read_data_0   = read_data_reg[0];
    assign read_data_1   = read_data_reg[1];
    assign ready         = (state_reg == ST_READY);
    assign write_dropped = write_dropped_reg;

endmodule

// File: tb/tb_register_file_bank.sv
// Directed testbench for register_file_bank: a 32-entry bank driven from a
// vector table plus hand-written reset/clear sequences, and a 16-entry bank
// for out-of-range writes and reads.
module tb_register_file_bank;

    logic        clk;
    logic        rst_n;

    logic [4:0]  a_waddr, a_r0, a_r1;
    logic [31:0] a_wdata;
    logic        a_we;
    logic [31:0] a_rd0, a_rd1;
    logic        a_ready, a_drop;

    logic [4:0]  b_waddr, b_r0, b_r1;
    logic [31:0] b_wdata;
    logic        b_we;
    logic [31:0] b_rd0, b_rd1;
    logic        b_ready, b_drop;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    register_file_bank #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .write_address(a_waddr), .write_data(a_wdata), .write_enable(a_we),
        .read_reg_0(a_r0), .read_reg_1(a_r1),
        .read_data_0(a_rd0), .read_data_1(a_rd1),
        .ready(a_ready), .write_dropped(a_drop)
    );

    register_file_bank #(.NUM_REGS(16), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .write_address(b_waddr), .write_data(b_wdata), .write_enable(b_we),
        .read_reg_0(b_r0), .read_reg_1(b_r1),
        .read_data_0(b_rd0), .read_data_1(b_rd1),
        .ready(b_ready), .write_dropped(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic        exp_drop;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Counts rising edges until dut_a reports ready; also records dut_b's latency.
    task automatic wait_ready(output int a_cnt, output int b_cnt, input bit inject_drop);
        a_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            a_cnt++;
            if (b_ready && b_cnt == 0) b_cnt = a_cnt;
            if (inject_drop) begin
                if (a_cnt == 1) check("drop_first_cycle", {31'd0, a_drop}, 32'd0);
                if (a_cnt == 3) check("drop_in_clear", {31'd0, a_drop}, 32'd1);
                if (a_cnt == 4) check("drop_clears", {31'd0, a_drop}, 32'd0);
                if (a_cnt == 2) begin
                    a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h12345678;
                end else begin
                    a_we = 1'b0;
                end
            end
            if (a_ready) break;
        end
        $display("clear sequence: ready after %0d cycles", a_cnt);
    endtask

    task automatic apply_a(input vec_t v, input int idx);
        @(negedge clk);
        a_we = v.we; a_waddr = v.waddr; a_wdata = v.wdata; a_r0 = v.r0; a_r1 = v.r1;
        @(posedge clk);
        #1;
        $display("vec %0d: we=%0b wa=%0d wd=0x%08h r0=%0d r1=%0d -> rd0=0x%08h rd1=0x%08h drop=%0b",
                 idx, v.we, v.waddr, v.wdata, v.r0, v.r1, a_rd0, a_rd1, a_drop);
        check($sformatf("vec%0d_rd0", idx), a_rd0, v.exp_rd0);
        check($sformatf("vec%0d_rd1", idx), a_rd1, v.exp_rd1);
        check($sformatf("vec%0d_drop", idx), {31'd0, a_drop}, {31'd0, v.exp_drop});
    endtask

    initial begin
        int a_cnt, b_cnt;

        vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd7,  32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd1,  32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 5'd9,  32'h1111,     5'd5,  5'd9,  32'hDEADBEEF, BYP ? 32'h1111 : 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 5'd9,  32'h2222,     5'd9,  5'd5,  BYP ? 32'h2222 : 32'h1111, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  32'h2222,     32'h2222,     1'b0};
        vecs[6]  = '{1'b1, 5'd1,  32'hA1,       5'd2,  5'd3,  32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b1, 5'd2,  32'hB2,       5'd1,  5'd3,  32'hA1,       32'h0,        1'b0};
        vecs[8]  = '{1'b1, 5'd3,  32'hC3,       5'd1,  5'd2,  32'hA1,       32'hB2,       1'b0};
        vecs[9]  = '{1'b1, 5'd4,  32'hD4,       5'd3,  5'd4,  32'hC3,       BYP ? 32'hD4 : 32'h0, 1'b0};
        vecs[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd4,  5'd0,  32'hD4,       32'h0,        1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 5'd31, 32'h5,        5'd31, 5'd31, BYP ? 32'h5 : 32'hFFFFFFFF, BYP ? 32'h5 : 32'hFFFFFFFF, 1'b0};

        rst_n = 1'b0;
        a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_r0 = 5'd3; a_r1 = 5'd0;
        b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_r0 = '0;   b_r1 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, a_ready}, 32'd0);
        check("reset_rd0", a_rd0, 32'h0);
        check("reset_rd1", a_rd1, 32'h0);
        check("reset_drop", {31'd0, a_drop}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(a_cnt, b_cnt, 1'b1);
        check("ready_latency_32", a_cnt, 32);
        check("ready_latency_16", b_cnt, 16);

        for (int i = 0; i < 13; i++) begin
            apply_a(vecs[i], i);
        end

        // Asynchronous reset mid-operation: outputs drop without waiting for an edge.
        @(negedge clk);
        a_we = 1'b0; a_r0 = 5'd1; a_r1 = 5'd2;
        rst_n = 1'b0;
        #1;
        $display("mid reset: ready=%0b rd0=0x%08h rd1=0x%08h", a_ready, a_rd0, a_rd1);
        check("midrst_ready", {31'd0, a_ready}, 32'd0);
        check("midrst_rd0", a_rd0, 32'h0);
        check("midrst_rd1", a_rd1, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(a_cnt, b_cnt, 1'b0);
        check("rerun_latency_32", a_cnt, 32);

        apply_a('{1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 32'h0, 32'h0, 1'b0}, 100);
        apply_a('{1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 32'h0, 32'h0, 1'b0}, 101);
        apply_a('{1'b0, 5'd0, 32'h0, 5'd7, 5'd31, 32'h0, 32'h0, 1'b0}, 102);

        // 16-entry bank: out-of-range write is dropped and reads beyond the array return 0.
        check("b_ready", {31'd0, b_ready}, 32'd1);
        @(negedge clk);
        b_we = 1'b1; b_waddr = 5'd4; b_wdata = 32'h4444;
        @(negedge clk);
        b_waddr = 5'd20; b_wdata = 32'hAAAA;
        @(posedge clk);
        #1;
        $display("b write 20: drop=%0b", b_drop);
        check("b_drop_oor", {31'd0, b_drop}, 32'd1);
        @(negedge clk);
        b_we = 1'b0; b_r0 = 5'd20; b_r1 = 5'd4;
        @(posedge clk);
        #1;
        $display("b read 20/4: rd0=0x%08h rd1=0x%08h drop=%0b", b_rd0, b_rd1, b_drop);
        check("b_drop_clears", {31'd0, b_drop}, 32'd0);
        check("b_rd_oor", b_rd0, 32'h0);
        check("b_reg4_kept", b_rd1, 32'h4444);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
